// File: rtl/bdd_walk_engine.sv
// Purpose: programmable BDD evaluator; walks one decision diagram per output channel over a captured input vector.
// Latency: sum over channels of (2*nodes_visited+1) cycles from accept to out_valid; one node per two cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module bdd_walk_engine #(
  parameter int IN_W       = 1894,
  parameter int IDX_W      = $clog2(IN_W),
  parameter int NODE_DEPTH = 256,
  parameter int PTR_W      = $clog2(NODE_DEPTH) + 1,
  parameter int NODE_W     = IDX_W + 2 * PTR_W,
  parameter int OUT_CH     = 64,
  parameter int CH_W       = $clog2(OUT_CH),
  parameter int MAX_STEPS  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [PTR_W-2:0]  prog_addr,
  input  logic [NODE_W-1:0] prog_data,
  input  logic              root_we,
  input  logic [CH_W-1:0]   root_ch,
  input  logic [PTR_W-1:0]  root_ptr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_CH-1:0] out_bits,
  output logic              err_loop,
  output logic              err_idx,
  output logic              prog_err
);

  localparam int ADDR_W     = PTR_W - 1;
  localparam int PHYS_DEPTH = 1 << ADDR_W;
  localparam int STEP_W     = $clog2(MAX_STEPS + 1);
  localparam logic [PTR_W-1:0] TERM0    = {1'b1, {(PTR_W-1){1'b0}}};
  localparam logic [IDX_W:0]   IN_W_EXT = (IDX_W+1)'(IN_W);

  typedef enum logic [1:0] {IDLE, STEP, FETCH, DONE} state_t;

  state_t state, state_nxt;

  // Physical depth is the full power of two so an over-range pointer simply wraps.
  logic [NODE_W-1:0] node_mem [PHYS_DEPTH];
  logic [NODE_W-1:0] node_q;
  logic [PTR_W-1:0]  root_tbl [OUT_CH];
  logic [IN_W-1:0]   in_q;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [STEP_W-1:0] steps;

  logic              rd_en;
  logic              prog_ok;
  logic              root_ok;
  logic              accept;
  logic              is_term;
  logic              at_limit;
  logic              last_ch;
  logic              ch_end;
  logic [IDX_W-1:0]  var_idx;
  logic [PTR_W-1:0]  lo_ptr;
  logic [PTR_W-1:0]  hi_ptr;
  logic              idx_bad;
  logic              sel_bit;
  logic [PTR_W-1:0]  root0_eff;

  assign prog_ok  = prog_we && (state == IDLE);
  assign root_ok  = root_we && (state == IDLE);
  assign accept   = in_valid && (state == IDLE);
  assign is_term  = ptr[PTR_W-1];
  assign at_limit = (steps == STEP_W'(MAX_STEPS));
  assign last_ch  = (ch == CH_W'(OUT_CH - 1));
  assign ch_nxt   = ch + CH_W'(1);
  assign ch_end   = (state == STEP) && (is_term || at_limit);

  assign {var_idx, lo_ptr, hi_ptr} = node_q;
  assign idx_bad = ({1'b0, var_idx} >= IN_W_EXT);
  assign sel_bit = idx_bad ? 1'b0 : in_q[var_idx];

  // A root write in the accept cycle must be seen by channel 0 of that evaluation.
  assign root0_eff = (root_ok && (root_ch == '0)) ? root_ptr : root_tbl[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = STEP;
      end
      STEP: begin
        if (is_term || at_limit) begin
          if (last_ch) state_nxt = DONE;
        end else begin
          rd_en     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = STEP;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Node RAM: write port for firmware, synchronous read port for the walker; contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_ok) node_mem[prog_addr] <= prog_data;
    if (rd_en)   node_q <= node_mem[ptr[ADDR_W-1:0]];
  end

  // Input vector snapshot taken at accept so later bus changes cannot disturb the walk.
  always_ff @(posedge clk) begin
    if (accept) in_q <= in_vec;
  end

  // Per-channel root table, every entry resetting to terminal-0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUT_CH; i++) root_tbl[i] <= TERM0;
    end else if (root_ok) begin
      root_tbl[root_ch] <= root_ptr;
    end
  end

  // Walk datapath: channel/pointer/step tracking, result bits, error flags and dropped-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch       <= '0;
      ptr      <= TERM0;
      steps    <= '0;
      out_bits <= '0;
      err_loop <= 1'b0;
      err_idx  <= 1'b0;
      prog_err <= 1'b0;
    end else begin
      prog_err <= (prog_we || root_we) && (state != IDLE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            ch       <= '0;
            ptr      <= root0_eff;
            steps    <= '0;
            err_loop <= 1'b0;
            err_idx  <= 1'b0;
          end
        end
        STEP: begin
          if (ch_end) begin
            // A terminal wins over the step limit; an aborted channel reads as 0.
            out_bits[ch] <= is_term ? ptr[0] : 1'b0;
            if (!is_term) err_loop <= 1'b1;
            if (!last_ch) begin
              ch    <= ch_nxt;
              ptr   <= root_tbl[ch_nxt];
              steps <= '0;
            end
          end
        end
        FETCH: begin
          if (idx_bad) err_idx <= 1'b1;
          ptr   <= sel_bit ? hi_ptr : lo_ptr;
          steps <= steps + STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bdd_walk_engine.sv
// Bench for bdd_walk_engine with a small 12-bit build so out-of-range variable indices are reachable.
// Directed scenarios plus randomized programs checked against a diagram-walking reference model.
module tb_bdd_walk_engine;

  localparam int IN_W       = 12;
  localparam int NODE_DEPTH = 16;
  localparam int OUT_CH     = 2;
  localparam int MAX_STEPS  = 8;
  localparam int IDX_W      = 4;
  localparam int PTR_W      = 5;
  localparam int NODE_W     = 14;
  localparam int CH_W       = 1;
  localparam int T0         = 16;
  localparam int T1         = 17;
  localparam int LIMIT      = 200;

  logic              clk;
  logic              rst;
  logic              prog_we;
  logic [PTR_W-2:0]  prog_addr;
  logic [NODE_W-1:0] prog_data;
  logic              root_we;
  logic [CH_W-1:0]   root_ch;
  logic [PTR_W-1:0]  root_ptr;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_vec;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_CH-1:0] out_bits;
  logic              err_loop;
  logic              err_idx;
  logic              prog_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_idx  [NODE_DEPTH];
  int m_lo   [NODE_DEPTH];
  int m_hi   [NODE_DEPTH];
  int m_root [OUT_CH];

  bdd_walk_engine #(
    .IN_W(IN_W), .NODE_DEPTH(NODE_DEPTH), .OUT_CH(OUT_CH), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .root_we(root_we), .root_ch(root_ch), .root_ptr(root_ptr),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
    .err_loop(err_loop), .err_idx(err_idx), .prog_err(prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // Reference: follow each channel's diagram from its root with plain integer arithmetic.
  task automatic model_eval(input int v, output int bits, output int el, output int ei, output int cycles);
    int p;
    int k;
    int b;
    bits = 0; el = 0; ei = 0; cycles = 0;
    for (int c = 0; c < OUT_CH; c++) begin
      p = m_root[c];
      k = 0;
      while (p < NODE_DEPTH && k < MAX_STEPS) begin
        if (m_idx[p] >= IN_W) begin
          ei = 1;
          b  = 0;
        end else begin
          b = (v >> m_idx[p]) & 1;
        end
        p = (b != 0) ? m_hi[p] : m_lo[p];
        k++;
      end
      if (p >= NODE_DEPTH) b = p & 1;
      else begin
        b  = 0;
        el = 1;
      end
      bits   = bits | (b << c);
      cycles = cycles + 2 * k + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic prog_node(input int a, input int idx, input int lo, input int hi);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = {4'(idx), 5'(lo), 5'(hi)};
    @(negedge clk);
    prog_we = 1'b0;
    m_idx[a] = idx; m_lo[a] = lo; m_hi[a] = hi;
  endtask

  task automatic set_root(input int c, input int p);
    @(negedge clk);
    root_we  = 1'b1;
    root_ch  = 1'(c);
    root_ptr = 5'(p);
    @(negedge clk);
    root_we = 1'b0;
    m_root[c] = p;
  endtask

  task automatic start_run(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in_vec   = IN_W'(v);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec   = IN_W'($urandom);
    cyc = 0;
  endtask

  task automatic finish_run(input string name, input int eb, input int el, input int ei, input int ec);
    while (out_valid !== 1'b1 && cyc < LIMIT) tick();
    total++;
    if (cyc != ec) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles want %0d", name, cyc, ec);
    end
    total++;
    if (out_bits !== 2'(eb)) begin
      bad++;
      $display("FAIL %s out_bits: got %b want %b", name, out_bits, 2'(eb));
    end
    total++;
    if (err_loop !== 1'(el) || err_idx !== 1'(ei)) begin
      bad++;
      $display("FAIL %s flags: got loop=%b idx=%b want loop=%0d idx=%0d", name, err_loop, err_idx, el, ei);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic run_model(input string name, input int v);
    int eb, el, ei, ec;
    model_eval(v, eb, el, ei, ec);
    start_run(v);
    finish_run(name, eb, el, ei, ec);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < OUT_CH; c++) m_root[c] = T0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if (out_bits !== 2'b00 || err_loop !== 1'b0 || err_idx !== 1'b0 || prog_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs: got bits=%b loop=%b idx=%b perr=%b want all 0", out_bits, err_loop, err_idx, prog_err);
    end
  endtask

  task automatic test_unprogrammed();
    start_run(0);
    finish_run("unprog", 0, 0, 0, 2);
  endtask

  task automatic test_chain();
    prog_node(0, 3, 1, T1);
    prog_node(1, 9, T0, T1);
    set_root(0, 0);
    set_root(1, T1);
    start_run(12'h200);
    finish_run("chain_b9_1", 2'b11, 0, 0, 6);
    start_run(12'h000);
    finish_run("chain_b9_0", 2'b10, 0, 0, 6);
    start_run(12'h008);
    finish_run("chain_b3_1", 2'b11, 0, 0, 4);
  endtask

  task automatic test_write_with_accept();
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'd5;
    prog_data = {4'd2, 5'(T0), 5'(T1)};
    root_we   = 1'b1;
    root_ch   = 1'b0;
    root_ptr  = 5'd5;
    in_valid  = 1'b1;
    in_vec    = 12'h004;
    @(negedge clk);
    prog_we = 1'b0; root_we = 1'b0; in_valid = 1'b0;
    in_vec  = 12'h000;
    cyc = 0;
    m_idx[5] = 2; m_lo[5] = T0; m_hi[5] = T1; m_root[0] = 5;
    finish_run("write_accept", 2'b11, 0, 0, 4);
  endtask

  task automatic test_loop();
    prog_node(2, 0, 2, 2);
    set_root(0, 2);
    start_run(int'($urandom_range(0, 4095)));
    finish_run("loop", 2'b10, 1, 0, 18);
  endtask

  task automatic test_bad_idx();
    prog_node(3, 15, T0, T1);
    prog_node(4, 12, 1, T1);
    set_root(0, 3);
    start_run(12'hFFF);
    finish_run("badidx_15", 2'b10, 0, 1, 4);
    set_root(0, 4);
    start_run(12'h200);
    finish_run("badidx_12", 2'b11, 0, 1, 6);
  endtask

  task automatic test_busy_write();
    int eb, el, ei, ec;
    set_root(0, 0);
    model_eval(12'h200, eb, el, ei, ec);
    start_run(12'h200);
    prog_we   = 1'b1;
    prog_addr = 4'd1;
    prog_data = {4'd1, 5'(T0), 5'(T0)};
    root_we   = 1'b1;
    root_ch   = 1'b1;
    root_ptr  = 5'(T0);
    tick();
    prog_we = 1'b0; root_we = 1'b0;
    total++;
    if (prog_err !== 1'b1) begin
      bad++;
      $display("FAIL busy_pulse_hi: got prog_err=%b want 1", prog_err);
    end
    tick();
    total++;
    if (prog_err !== 1'b0) begin
      bad++;
      $display("FAIL busy_pulse_lo: got prog_err=%b want 0", prog_err);
    end
    finish_run("busy_run", eb, el, ei, ec);
    run_model("busy_after_a", 12'h200);
    run_model("busy_after_b", 12'h000);
  endtask

  task automatic test_backpressure();
    int eb, el, ei, ec;
    model_eval(12'h200, eb, el, ei, ec);
    start_run(12'h200);
    while (out_valid !== 1'b1 && cyc < LIMIT) tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        in_vec   = 12'h000;
      end
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bits !== 2'(eb)) begin
        bad++;
        $display("FAIL backpressure_%0d: got valid=%b ready=%b bits=%b want 1/0/%b", i, out_valid, in_ready, out_bits, 2'(eb));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    cyc = 0;
    finish_run("backpressure_end", eb, el, ei, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < NODE_DEPTH; n++)
      prog_node(n, int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    for (int r = 0; r < 4; r++) begin
      set_root(0, int'($urandom_range(0, 31)));
      set_root(1, int'($urandom_range(0, 17)));
      for (int i = 0; i < 5; i++) run_model("random", int'($urandom_range(0, 4095)));
    end
  endtask

  task automatic test_rst_midwalk();
    set_root(0, 0);
    set_root(1, 1);
    start_run(int'($urandom_range(0, 4095)));
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < OUT_CH; c++) m_root[c] = T0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    start_run(int'($urandom_range(0, 4095)));
    finish_run("rst_roots", 2'b00, 0, 0, 2);
    set_root(0, 0);
    set_root(1, 1);
    for (int i = 0; i < 4; i++) run_model("ram_kept", int'($urandom_range(0, 4095)));
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    root_we = 1'b0; root_ch = '0; root_ptr = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    test_reset();
    test_unprogrammed();
    test_chain();
    test_write_with_accept();
    test_loop();
    test_bad_idx();
    test_busy_write();
    test_backpressure();
    test_random();
    test_rst_midwalk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
